// File: rtl/fir_mac_sequencer.sv
// Control sequencer that time-multiplexes a DSP48A1 slice as an NTAPS direct-form FIR.
// Streams one coef/sample product per cycle, drains the slice pipeline, then saturates P onto Y.
module fir_mac_sequencer #(
  parameter int NTAPS      = 8,
  parameter int PIPE_LAT   = 3,
  parameter int OPMODE_DLY = 1,
  parameter int OUT_SHIFT  = 0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [17:0] S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic        COEF_WE,
  input  logic [5:0]  COEF_ADDR,
  input  logic [17:0] COEF_DATA,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  input  logic [47:0] DSP_P,
  output logic [17:0] Y_DATA,
  output logic        Y_SAT,
  output logic        Y_VALID,
  input  logic        Y_READY
);

  localparam int KW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int CMAX = (NTAPS > PIPE_LAT) ? NTAPS : PIPE_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [7:0]  OP_FIRST = 8'h01;
  localparam logic [7:0]  OP_ACC   = 8'h09;
  localparam logic [7:0]  OP_HOLD  = 8'h08;
  localparam logic [47:0] Y_MAX    = 48'd262143;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [17:0]   r_coef [NTAPS];
  logic [17:0]   r_x    [NTAPS];
  logic [17:0]   r_y;
  logic          r_sat;

  logic          w_accept;
  logic          w_coef_wr;
  logic          w_run_last;
  logic          w_drain_last;
  logic [KW-1:0] w_tap;
  logic [7:0]    w_opcode;

  // Logical shift of P, then clamp to the unsigned 18-bit range; MSB of the result is the sat flag.
  function automatic logic [18:0] f_scale_sat(input logic [47:0] p);
    logic [47:0] s;
    s = p >> OUT_SHIFT;
    if (s > Y_MAX) f_scale_sat = {1'b1, 18'h3FFFF};
    else           f_scale_sat = {1'b0, s[17:0]};
  endfunction

  assign w_accept     = S_VALID && S_READY;
  assign w_coef_wr    = (r_state == S_IDLE) && COEF_WE && ({1'b0, COEF_ADDR} < 7'(NTAPS));
  assign w_run_last   = (r_cnt == CW'(NTAPS - 1));
  assign w_drain_last = (r_cnt == CW'(PIPE_LAT - 1));
  assign w_tap        = r_cnt[KW-1:0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_run_last) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // P holds the last tap's sum on the final drain edge.
          if (w_drain_last) begin
            r_state        <= S_OUT;
            r_cnt          <= '0;
            {r_sat, r_y}   <= f_scale_sat(DSP_P);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (Y_READY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Coefficient write and sample accept share an edge; the new coef is read in RUN, so the write wins.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
    end else begin
      if (w_coef_wr) r_coef[COEF_ADDR[KW-1:0]] <= COEF_DATA;
      if (w_accept) begin
        r_x[0] <= S_DATA;
        for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
      end
    end
  end

  assign w_opcode = (r_state == S_RUN) ? ((r_cnt == '0) ? OP_FIRST : OP_ACC) : OP_HOLD;

  generate
    if (OPMODE_DLY == 0) begin : g_op_nodly
      assign DSP_OPMODE = w_opcode;
    end else begin : g_op_dly
      logic [7:0] r_op_p [OPMODE_DLY];
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          for (int i = 0; i < OPMODE_DLY; i++) r_op_p[i] <= OP_HOLD;
        end else begin
          r_op_p[0] <= w_opcode;
          for (int i = 1; i < OPMODE_DLY; i++) r_op_p[i] <= r_op_p[i-1];
        end
      end
      assign DSP_OPMODE = r_op_p[OPMODE_DLY-1];
    end
  endgenerate

  assign S_READY = (r_state == S_IDLE) && RSTN;
  assign DSP_A   = (r_state == S_RUN) ? r_coef[w_tap] : '0;
  assign DSP_B   = (r_state == S_RUN) ? r_x[w_tap]    : '0;
  assign DSP_CE  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign Y_VALID = (r_state == S_OUT);
  assign Y_DATA  = r_y;
  assign Y_SAT   = r_sat;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: two instances (OUT_SHIFT 0 and 2) each driving a behavioural DSP48A1 slice,
// checked every cycle against a tap-sum reference plus directed literal expectations.
module tb_fir_mac_sequencer;

  localparam int NT = 4;
  localparam int PL = 3;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [17:0] S_DATA;
  logic        S_VALID;
  logic        COEF_WE;
  logic [5:0]  COEF_ADDR;
  logic [17:0] COEF_DATA;
  logic        Y_READY;

  logic        s_ready [2];
  logic [17:0] dsp_a   [2];
  logic [17:0] dsp_b   [2];
  logic [7:0]  dsp_op  [2];
  logic        dsp_ce  [2];
  logic [17:0] y_data  [2];
  logic        y_sat   [2];
  logic        y_valid [2];

  // Slice model: A1/B1 reg, M reg, OPMODE reg, P reg, all gated by CE.
  logic [17:0] sl_a  [2] = '{default: '0};
  logic [17:0] sl_b  [2] = '{default: '0};
  logic [35:0] sl_m  [2] = '{default: '0};
  logic [7:0]  sl_op [2] = '{default: 8'h08};
  logic [47:0] sl_p  [2] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fir_mac_sequencer #(.NTAPS(NT), .PIPE_LAT(PL), .OPMODE_DLY(1), .OUT_SHIFT(0)) u_dut0 (
    .CLK(CLK), .RSTN(RSTN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(s_ready[0]),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
    .DSP_A(dsp_a[0]), .DSP_B(dsp_b[0]), .DSP_OPMODE(dsp_op[0]), .DSP_CE(dsp_ce[0]),
    .DSP_P(sl_p[0]), .Y_DATA(y_data[0]), .Y_SAT(y_sat[0]), .Y_VALID(y_valid[0]), .Y_READY(Y_READY)
  );

  fir_mac_sequencer #(.NTAPS(NT), .PIPE_LAT(PL), .OPMODE_DLY(1), .OUT_SHIFT(2)) u_dut1 (
    .CLK(CLK), .RSTN(RSTN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(s_ready[1]),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
    .DSP_A(dsp_a[1]), .DSP_B(dsp_b[1]), .DSP_OPMODE(dsp_op[1]), .DSP_CE(dsp_ce[1]),
    .DSP_P(sl_p[1]), .Y_DATA(y_data[1]), .Y_SAT(y_sat[1]), .Y_VALID(y_valid[1]), .Y_READY(Y_READY)
  );

  function automatic logic [47:0] slice_next(input logic [7:0] op, input logic [35:0] m, input logic [47:0] p);
    logic [47:0] x;
    logic [47:0] z;
    x = (op[1:0] == 2'b01) ? {12'b0, m} : 48'd0;
    z = (op[3:2] == 2'b10) ? p : 48'd0;
    return x + z;
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (dsp_ce[i]) begin
        sl_p[i]  <= slice_next(sl_op[i], sl_m[i], sl_p[i]);
        sl_m[i]  <= 36'(sl_a[i]) * 36'(sl_b[i]);
        sl_a[i]  <= dsp_a[i];
        sl_b[i]  <= dsp_b[i];
        sl_op[i] <= dsp_op[i];
      end
    end
  end

  // Reference: coefficient bank, delay line, and a phase count n of cycles since the accept edge.
  logic [17:0] gcoef [NT] = '{default: '0};
  logic [17:0] gx    [NT] = '{default: '0};
  logic        m_busy = 1'b0;
  int          m_n = 0;
  logic [63:0] m_s [2] = '{default: '0};

  function automatic logic [63:0] golden(input int sh);
    logic [17:0] c  [NT];
    logic [17:0] xx [NT];
    logic [63:0] acc;
    c = gcoef;
    if (COEF_WE && int'(COEF_ADDR) < NT) c[int'(COEF_ADDR)] = COEF_DATA;
    xx[0] = S_DATA;
    for (int k = 1; k < NT; k++) xx[k] = gx[k-1];
    acc = 64'd0;
    for (int k = 0; k < NT; k++) acc = acc + 64'(c[k]) * 64'(xx[k]);
    return acc >> sh;
  endfunction

  function automatic logic [17:0] sat_val(input logic [63:0] s);
    return (s > 64'd262143) ? 18'h3FFFF : s[17:0];
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_busy <= 1'b0;
      m_n    <= 0;
      for (int k = 0; k < NT; k++) begin
        gcoef[k] <= '0;
        gx[k]    <= '0;
      end
    end else if (!m_busy) begin
      if (COEF_WE && int'(COEF_ADDR) < NT) gcoef[int'(COEF_ADDR)] <= COEF_DATA;
      if (S_VALID) begin
        gx[0] <= S_DATA;
        for (int k = 1; k < NT; k++) gx[k] <= gx[k-1];
        m_s[0] <= golden(0);
        m_s[1] <= golden(2);
        m_busy <= 1'b1;
        m_n    <= 1;
      end
    end else if (m_n >= NT + PL + 1) begin
      if (Y_READY) m_busy <= 1'b0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RSTN) begin
        chk($sformatf("rst d%0d S_READY", i), 64'(s_ready[i]), 64'd0);
        chk($sformatf("rst d%0d Y_VALID", i), 64'(y_valid[i]), 64'd0);
        chk($sformatf("rst d%0d Y_DATA", i), 64'(y_data[i]), 64'd0);
        chk($sformatf("rst d%0d Y_SAT", i), 64'(y_sat[i]), 64'd0);
        chk($sformatf("rst d%0d DSP_CE", i), 64'(dsp_ce[i]), 64'd0);
        chk($sformatf("rst d%0d DSP_A", i), 64'(dsp_a[i]), 64'd0);
        chk($sformatf("rst d%0d DSP_B", i), 64'(dsp_b[i]), 64'd0);
        chk($sformatf("rst d%0d DSP_OPMODE", i), 64'(dsp_op[i]), 64'h08);
      end else begin
        logic        e_vld;
        logic        e_ce;
        logic [17:0] e_a;
        logic [17:0] e_b;
        logic [7:0]  e_op;
        e_vld = m_busy && (m_n >= NT + PL + 1);
        e_ce  = m_busy && (m_n <= NT + PL);
        e_a   = (m_busy && m_n >= 1 && m_n <= NT) ? gcoef[m_n-1] : 18'd0;
        e_b   = (m_busy && m_n >= 1 && m_n <= NT) ? gx[m_n-1] : 18'd0;
        e_op  = (m_busy && m_n >= 2 && m_n <= NT + 1) ? ((m_n == 2) ? 8'h01 : 8'h09) : 8'h08;
        chk($sformatf("d%0d S_READY", i), 64'(s_ready[i]), 64'(!m_busy));
        chk($sformatf("d%0d Y_VALID", i), 64'(y_valid[i]), 64'(e_vld));
        chk($sformatf("d%0d DSP_CE", i), 64'(dsp_ce[i]), 64'(e_ce));
        chk($sformatf("d%0d DSP_A", i), 64'(dsp_a[i]), 64'(e_a));
        chk($sformatf("d%0d DSP_B", i), 64'(dsp_b[i]), 64'(e_b));
        chk($sformatf("d%0d DSP_OPMODE", i), 64'(dsp_op[i]), 64'(e_op));
        if (e_vld) begin
          chk($sformatf("d%0d Y_DATA", i), 64'(y_data[i]), 64'(sat_val(m_s[i])));
          chk($sformatf("d%0d Y_SAT", i), 64'(y_sat[i]), 64'(m_s[i] > 64'd262143));
        end
      end
    end
  end

  task automatic load(input int a, input logic [17:0] v);
    @(negedge CLK);
    COEF_WE   = 1'b1;
    COEF_ADDR = 6'(a);
    COEF_DATA = v;
    @(negedge CLK);
    COEF_WE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RSTN = 1'b1;
  endtask

  task automatic send(input logic [17:0] d, input bit we_same, input bit we_run,
                      input logic [17:0] e0, input bit s0, input logic [17:0] e1, input bit s1);
    int w;
    int lat;
    @(negedge CLK);
    S_DATA  = d;
    S_VALID = 1'b1;
    if (we_same) begin
      COEF_WE = 1'b1; COEF_ADDR = 6'd0; COEF_DATA = 18'd99;
    end
    w = 0;
    while (!s_ready[0] && w < 40) begin
      @(negedge CLK);
      w++;
    end
    chk("accept timeout", 64'(w >= 40), 64'd0);
    @(posedge CLK);
    #1;
    S_VALID = 1'b0;
    COEF_WE = 1'b0;
    if (we_run) begin
      COEF_WE = 1'b1; COEF_ADDR = 6'd0; COEF_DATA = 18'd99;
    end
    lat = 0;
    while (!y_valid[0] && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) COEF_WE = 1'b0;
    end
    chk("latency", 64'(lat), 64'd8);
    chk("lit d0 Y_DATA", 64'(y_data[0]), 64'(e0));
    chk("lit d0 Y_SAT", 64'(y_sat[0]), 64'(s0));
    chk("lit d1 Y_DATA", 64'(y_data[1]), 64'(e1));
    chk("lit d1 Y_SAT", 64'(y_sat[1]), 64'(s1));
    chk("model d0 Y", 64'(sat_val(m_s[0])), 64'(e0));
    chk("model d1 Y", 64'(sat_val(m_s[1])), 64'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RSTN = 1'b1; S_DATA = '0; S_VALID = 1'b0;
    COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0; Y_READY = 1'b1;
    #1 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset S_READY", 64'(s_ready[0]), 64'd0);
    chk("reset OPMODE", 64'(dsp_op[0]), 64'h08);
    #2 RSTN = 1'b1;

    // Impulse
    load(0, 18'd1); load(1, 18'd2); load(2, 18'd3); load(3, 18'd4);
    load(5, 18'd77);
    send(18'd1, 0, 0, 18'd1, 0, 18'd0, 0);
    send(18'd0, 0, 0, 18'd2, 0, 18'd0, 0);
    send(18'd0, 0, 0, 18'd3, 0, 18'd0, 0);
    send(18'd0, 0, 0, 18'd4, 0, 18'd1, 0);

    // Step from reset
    do_reset();
    load(0, 18'd1); load(1, 18'd2); load(2, 18'd3); load(3, 18'd4);
    send(18'd10, 0, 0, 18'd10, 0, 18'd2, 0);
    send(18'd20, 0, 0, 18'd40, 0, 18'd10, 0);
    send(18'd30, 0, 0, 18'd100, 0, 18'd25, 0);

    // Backpressure in OUT
    @(negedge CLK);
    Y_READY = 1'b0;
    send(18'd5, 0, 0, 18'd165, 0, 18'd41, 0);
    repeat (5) begin
      @(negedge CLK);
      chk("bp Y_DATA held", 64'(y_data[0]), 64'd165);
      chk("bp Y_VALID", 64'(y_valid[0]), 64'd1);
      chk("bp S_READY", 64'(s_ready[0]), 64'd0);
      chk("bp DSP_CE", 64'(dsp_ce[0]), 64'd0);
    end
    Y_READY = 1'b1;
    @(negedge CLK);
    chk("bp release S_READY", 64'(s_ready[0]), 64'd1);
    chk("bp release Y_VALID", 64'(y_valid[0]), 64'd0);

    // Coefficient write gating: dropped in RUN, applied with same-cycle accept in IDLE
    send(18'd0, 0, 1, 18'd180, 0, 18'd45, 0);
    send(18'd1, 1, 0, 18'd234, 0, 18'd58, 0);

    // Saturation boundary
    do_reset();
    load(0, 18'd131072);
    send(18'd4, 0, 0, 18'd262143, 1, 18'd131072, 0);
    load(0, 18'd262143);
    send(18'd1, 0, 0, 18'd262143, 0, 18'd65535, 0);

    // Asynchronous reset during tap 2
    load(1, 18'd3);
    @(negedge CLK);
    S_DATA = 18'd7; S_VALID = 1'b1;
    @(posedge CLK);
    #1 S_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("async Y_VALID", 64'(y_valid[0]), 64'd0);
    chk("async S_READY", 64'(s_ready[0]), 64'd0);
    chk("async DSP_CE", 64'(dsp_ce[0]), 64'd0);
    chk("async DSP_A", 64'(dsp_a[0]), 64'd0);
    chk("async DSP_OPMODE", 64'(dsp_op[0]), 64'h08);
    chk("async Y_DATA", 64'(y_data[0]), 64'd0);
    repeat (3) @(negedge CLK);
    #2 RSTN = 1'b1;
    repeat (12) @(negedge CLK);
    chk("post-abort Y_VALID", 64'(y_valid[0]), 64'd0);
    send(18'd5, 0, 0, 18'd0, 0, 18'd0, 0);
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
